// File: rtl/eer_rl_pkg.sv
// Shared types and constants for the reward-stage TX framer.
package eer_rl_pkg;

    localparam int unsigned WORD_WIDTH = 16;
    localparam int unsigned DROP_CW    = 8;
    localparam int unsigned TYPE_W     = 3;
    localparam int unsigned FRAME_LEN  = 10;
    localparam int unsigned CNT_W      = 4;

    localparam logic [7:0]       SYNC_BYTE = 8'hA5;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [TYPE_W-1:0] {
        PKT_INVALID = 3'd0,
        PKT_HELLO   = 3'd1,
        PKT_CH_ADV  = 3'd2,
        PKT_JOIN    = 3'd3,
        PKT_DATA    = 3'd4,
        PKT_REWARD  = 3'd5,
        PKT_ACK     = 3'd6,
        PKT_RSVD    = 3'd7
    } pkt_type_t;

    typedef struct packed {
        pkt_type_t             ptype;
        logic [WORD_WIDTH-1:0] src_id;
        logic [WORD_WIDTH-1:0] dst_id;
        logic [WORD_WIDTH-1:0] src_hops;
        logic [WORD_WIDTH-1:0] energy;
        logic [WORD_WIDTH-1:0] q_value;
        logic [WORD_WIDTH-1:0] chosen_ch;
        logic [WORD_WIDTH-1:0] hops_from_ch;
        logic [WORD_WIDTH-1:0] timeslot;
    } reward_pkt_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } framer_state_t;

    // Payload words W0..W8; the checksum word is supplied by the framer.
    function automatic logic [WORD_WIDTH-1:0] frame_word(input reward_pkt_t pkt,
                                                         input logic [CNT_W-1:0] idx);
        logic [WORD_WIDTH-1:0] w;
        w = '0;
        case (idx)
            4'd0:    w = {pkt.ptype, 5'(FRAME_LEN), SYNC_BYTE};
            4'd1:    w = pkt.src_id;
            4'd2:    w = pkt.dst_id;
            4'd3:    w = pkt.src_hops;
            4'd4:    w = pkt.energy;
            4'd5:    w = pkt.q_value;
            4'd6:    w = pkt.chosen_ch;
            4'd7:    w = pkt.hops_from_ch;
            4'd8:    w = pkt.timeslot;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/reward_pkt_slot2.sv
// Two-entry in-order packet store: active slot feeds the framer, pending slot queues one more.
module reward_pkt_slot2
    import eer_rl_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        push,
    input  reward_pkt_t push_pkt,
    input  logic        pop,
    output reward_pkt_t act_pkt,
    output logic        act_full,
    output logic        pend_full
);

    reward_pkt_t pend_pkt;

    // A push alongside a pop lands wherever the post-pop occupancy leaves room.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            act_pkt   <= '0;
            pend_pkt  <= '0;
            act_full  <= 1'b0;
            pend_full <= 1'b0;
        end else if (pop && pend_full) begin
            act_pkt   <= pend_pkt;
            pend_full <= push;
            if (push) begin
                pend_pkt <= push_pkt;
            end
        end else if (pop) begin
            act_full <= push;
            if (push) begin
                act_pkt <= push_pkt;
            end
        end else if (push && !act_full) begin
            act_full <= 1'b1;
            act_pkt  <= push_pkt;
        end else if (push && !pend_full) begin
            pend_full <= 1'b1;
            pend_pkt  <= push_pkt;
        end
    end

endmodule

// File: rtl/reward_tx_framer.sv
// Captures reward-stage packets and serialises them as 10-word frames over a valid/ready link.
module reward_tx_framer
    import eer_rl_pkg::*;
(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  reward_done,
    input  logic [TYPE_W-1:0]     rPacketType,
    input  logic [WORD_WIDTH-1:0] rSourceID,
    input  logic [WORD_WIDTH-1:0] rDestinationID,
    input  logic [WORD_WIDTH-1:0] rSourceHops,
    input  logic [WORD_WIDTH-1:0] rEnergyLeft,
    input  logic [WORD_WIDTH-1:0] rQValue,
    input  logic [WORD_WIDTH-1:0] rChosenCH,
    input  logic [WORD_WIDTH-1:0] rHopsFromCH,
    input  logic [WORD_WIDTH-1:0] rTimeslot,
    input  logic                  tx_ready,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_sof,
    output logic                  tx_eof,
    output logic                  busy,
    output logic                  drop_pulse,
    output logic [DROP_CW-1:0]    drop_count
);

    framer_state_t         state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n, cnt_inc;
    logic [WORD_WIDTH-1:0] csum, csum_n;
    logic [WORD_WIDTH-1:0] data_n;
    logic                  valid_n, sof_n, eof_n;
    logic                  pop, capture, drop;
    logic                  act_full, pend_full;
    reward_pkt_t           pkt_in, act_pkt;

    always_comb begin
        pkt_in              = '0;
        pkt_in.ptype        = pkt_type_t'(rPacketType);
        pkt_in.src_id       = rSourceID;
        pkt_in.dst_id       = rDestinationID;
        pkt_in.src_hops     = rSourceHops;
        pkt_in.energy       = rEnergyLeft;
        pkt_in.q_value      = rQValue;
        pkt_in.chosen_ch    = rChosenCH;
        pkt_in.hops_from_ch = rHopsFromCH;
        pkt_in.timeslot     = rTimeslot;
    end

    // Admission uses pre-edge occupancy, so a full store drops even while popping.
    assign capture = reward_done && (rPacketType != '0) && !(act_full && pend_full);
    assign drop    = reward_done && !capture;
    assign busy    = act_full || pend_full;

    reward_pkt_slot2 u_slots (
        .clk       (clk),
        .nrst      (nrst),
        .push      (capture),
        .push_pkt  (pkt_in),
        .pop       (pop),
        .act_pkt   (act_pkt),
        .act_full  (act_full),
        .pend_full (pend_full)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= IDLE;
            cnt        <= '0;
            csum       <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            tx_sof     <= 1'b0;
            tx_eof     <= 1'b0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            csum       <= csum_n;
            tx_data    <= data_n;
            tx_valid   <= valid_n;
            tx_sof     <= sof_n;
            tx_eof     <= eof_n;
            drop_pulse <= drop;
            if (drop && (drop_count != '1)) begin
                drop_count <= DROP_CW'(drop_count + 1'b1);
            end
        end
    end

    // Next-state and next-output logic; outputs are loaded one cycle ahead.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        csum_n  = csum;
        data_n  = tx_data;
        valid_n = tx_valid;
        sof_n   = tx_sof;
        eof_n   = tx_eof;
        pop     = 1'b0;
        cnt_inc = CNT_W'(cnt + 1'b1);

        unique case (state)
            IDLE: begin
                if (act_full) begin
                    state_n = SEND;
                    cnt_n   = '0;
                    csum_n  = '0;
                    valid_n = 1'b1;
                    data_n  = frame_word(act_pkt, '0);
                    sof_n   = 1'b1;
                    eof_n   = 1'b0;
                end
            end
            SEND: begin
                if (!tx_valid) begin
                    // Gap cycle after a frame: restart with the promoted pending packet.
                    cnt_n   = '0;
                    csum_n  = '0;
                    valid_n = 1'b1;
                    data_n  = frame_word(act_pkt, '0);
                    sof_n   = 1'b1;
                    eof_n   = 1'b0;
                end else if (tx_ready) begin
                    if (cnt == LAST_IDX) begin
                        pop     = 1'b1;
                        cnt_n   = '0;
                        valid_n = 1'b0;
                        data_n  = '0;
                        sof_n   = 1'b0;
                        eof_n   = 1'b0;
                        state_n = pend_full ? SEND : IDLE;
                    end else begin
                        csum_n = csum ^ tx_data;
                        cnt_n  = cnt_inc;
                        sof_n  = 1'b0;
                        eof_n  = (cnt_inc == LAST_IDX);
                        data_n = (cnt_inc == LAST_IDX) ? csum_n : frame_word(act_pkt, cnt_inc);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reward_tx_framer.sv
// Directed bench for reward_tx_framer with hand-computed frames.
module tb_reward_tx_framer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        reward_done;
    logic [2:0]  rPacketType;
    logic [15:0] rSourceID, rDestinationID, rSourceHops, rEnergyLeft;
    logic [15:0] rQValue, rChosenCH, rHopsFromCH, rTimeslot;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_valid, tx_sof, tx_eof, busy, drop_pulse;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] q_data[$];
    logic        q_sof[$];
    logic        q_eof[$];
    int          q_cyc[$];

    logic [15:0] pf1[8] = '{16'h000C, 16'h0001, 16'h0001, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [15:0] e1[10] = '{16'h2AA5, 16'h000C, 16'h0001, 16'h0001, 16'h8000,
                            16'h0, 16'h0, 16'h0, 16'h0, 16'hAAA9};
    logic [15:0] pf2[8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                            16'h5555, 16'h6666, 16'h7777, 16'h8888};
    logic [15:0] e2[10] = '{16'h4AA5, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                            16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'hC22D};
    logic [15:0] pf3[8] = '{16'h00AB, 16'h00CD, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [15:0] e3[10] = '{16'h6AA5, 16'h00AB, 16'h00CD, 16'h0, 16'h0,
                            16'h0, 16'h0, 16'h0, 16'h0, 16'h6AC3};
    logic [15:0] pf5[8] = '{16'hDEAD, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

    reward_tx_framer dut (
        .clk            (clk),
        .nrst           (nrst),
        .reward_done    (reward_done),
        .rPacketType    (rPacketType),
        .rSourceID      (rSourceID),
        .rDestinationID (rDestinationID),
        .rSourceHops    (rSourceHops),
        .rEnergyLeft    (rEnergyLeft),
        .rQValue        (rQValue),
        .rChosenCH      (rChosenCH),
        .rHopsFromCH    (rHopsFromCH),
        .rTimeslot      (rTimeslot),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_sof         (tx_sof),
        .tx_eof         (tx_eof),
        .busy           (busy),
        .drop_pulse     (drop_pulse),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    // Record every accepted word with its flags and cycle number.
    always @(posedge clk) begin
        if (nrst && tx_valid && tx_ready) begin
            q_data.push_back(tx_data);
            q_sof.push_back(tx_sof);
            q_eof.push_back(tx_eof);
            q_cyc.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_sof.delete();
        q_eof.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        clear_q();
    endtask

    // Drives a one-cycle strobe starting now; returns 1 time unit after the capture edge.
    task automatic send_reward(input logic [2:0] t, input logic [15:0] f[8]);
        reward_done    = 1'b1;
        rPacketType    = t;
        rSourceID      = f[0];
        rDestinationID = f[1];
        rSourceHops    = f[2];
        rEnergyLeft    = f[3];
        rQValue        = f[4];
        rChosenCH      = f[5];
        rHopsFromCH    = f[6];
        rTimeslot      = f[7];
        @(posedge clk);
        #1;
        reward_done = 1'b0;
    endtask

    task automatic wait_words(input int n, input int max_cycles, input string tag);
        int k;
        k = 0;
        while (q_data.size() < n && k < max_cycles) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (q_data.size() < n) check({tag, "_timeout"}, 32'(q_data.size()), 32'(n));
    endtask

    task automatic check_frame(input int base, input logic [15:0] e[10], input string tag);
        for (int i = 0; i < 10; i++) begin
            if (base + i < q_data.size()) begin
                check($sformatf("%s_w%0d", tag, i), 32'(q_data[base+i]), 32'(e[i]));
                check($sformatf("%s_sof%0d", tag, i), 32'(q_sof[base+i]), 32'(i == 0));
                check($sformatf("%s_eof%0d", tag, i), 32'(q_eof[base+i]), 32'(i == 9));
            end else begin
                check($sformatf("%s_missing%0d", tag, i), 32'(q_data.size()), 32'(base + i + 1));
            end
        end
    endtask

    initial begin
        reward_done = 1'b0;
        rPacketType = '0;
        {rSourceID, rDestinationID, rSourceHops, rEnergyLeft} = '0;
        {rQValue, rChosenCH, rHopsFromCH, rTimeslot} = '0;
        tx_ready = 1'b1;
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dcnt", 32'(drop_count), 0);
        check("rst_sof_eof", 32'({tx_sof, tx_eof, drop_pulse}), 0);
        nrst = 1'b1;

        // T1 single frame and first-valid latency
        send_reward(3'd1, pf1);
        check("t1_busy", 32'(busy), 1);
        check("t1_valid_n1", 32'(tx_valid), 0);
        @(posedge clk);
        #1;
        check("t1_valid_n2", 32'(tx_valid), 1);
        check("t1_w0_early", 32'(tx_data), 32'h2AA5);
        check("t1_sof_early", 32'(tx_sof), 1);
        wait_words(10, 40, "t1");
        check_frame(0, e1, "t1");
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_idle_valid", 32'(tx_valid), 0);

        // T2 backpressure at cnt=4
        do_reset();
        send_reward(3'd2, pf2);
        wait_words(4, 40, "t2a");
        tx_ready = 1'b0;
        check("t2_hold0", 32'(tx_data), 32'h4444);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t2_hold_data", 32'(tx_data), 32'h4444);
            check("t2_hold_valid", 32'(tx_valid), 1);
            check("t2_hold_cnt", 32'(q_data.size()), 4);
        end
        tx_ready = 1'b1;
        wait_words(10, 40, "t2b");
        check_frame(0, e2, "t2");

        // T3 back-to-back with a one-cycle gap
        do_reset();
        send_reward(3'd1, pf1);
        wait_words(2, 40, "t3a");
        send_reward(3'd3, pf3);
        check("t3_dpulse", 32'(drop_pulse), 0);
        wait_words(20, 80, "t3b");
        check_frame(0, e1, "t3a");
        check_frame(10, e3, "t3b");
        if (q_cyc.size() >= 11) check("t3_gap", 32'(q_cyc[10] - q_cyc[9]), 2);
        check("t3_dcnt", 32'(drop_count), 0);

        // T4 overflow: third packet dropped, never sent
        do_reset();
        send_reward(3'd1, pf1);
        wait_words(1, 40, "t4a");
        send_reward(3'd2, pf2);
        check("t4_b_dpulse", 32'(drop_pulse), 0);
        send_reward(3'd5, pf5);
        check("t4_c_dpulse", 32'(drop_pulse), 1);
        check("t4_dcnt", 32'(drop_count), 1);
        check("t4_busy", 32'(busy), 1);
        wait_words(20, 80, "t4b");
        check_frame(0, e1, "t4a");
        check_frame(10, e2, "t4b");
        repeat (30) @(posedge clk);
        #1;
        check("t4_no_third", 32'(q_data.size()), 20);
        check("t4_dcnt_end", 32'(drop_count), 1);

        // T5 invalid type
        do_reset();
        send_reward(3'd0, pf1);
        check("t5_dpulse", 32'(drop_pulse), 1);
        check("t5_dcnt", 32'(drop_count), 1);
        check("t5_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        check("t5_dpulse_off", 32'(drop_pulse), 0);
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_words", 32'(q_data.size()), 0);
        check("t5_valid", 32'(tx_valid), 0);

        // T6 reset mid-frame
        do_reset();
        send_reward(3'd2, pf2);
        wait_words(5, 40, "t6a");
        nrst = 1'b0;
        @(posedge clk);
        #1;
        check("t6_valid", 32'(tx_valid), 0);
        check("t6_data", 32'(tx_data), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_flags", 32'({tx_sof, tx_eof, drop_pulse}), 0);
        nrst = 1'b1;
        clear_q();
        send_reward(3'd1, pf1);
        wait_words(10, 40, "t6b");
        check_frame(0, e1, "t6");

        // T7 drop counter saturation
        do_reset();
        reward_done = 1'b1;
        rPacketType = 3'd0;
        repeat (254) @(posedge clk);
        #1;
        check("t7_dcnt_fe", 32'(drop_count), 32'hFE);
        repeat (2) @(posedge clk);
        #1;
        check("t7_dcnt_sat", 32'(drop_count), 32'hFF);
        check("t7_dpulse_sat", 32'(drop_pulse), 1);
        reward_done = 1'b0;
        @(posedge clk);
        #1;
        check("t7_dcnt_hold", 32'(drop_count), 32'hFF);
        check("t7_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
